// File: rtl/gate_slew_ctrl.sv
// Gate-period divider with AXI-S slew commands for fine phase steering.
// Each signed command shortens or lengthens that many gate periods by DELTA cycles.
module gate_slew_ctrl #(
    parameter int DIV_GATE              = 2000000,
    parameter int DIV_GATE_INCDEC_DELTA = DIV_GATE / 2000,
    parameter int SLEW_BYTES            = 4
) (
    input  logic                      i_clk_gate,
    input  logic                      rst_gate,
    input  logic [7:0]                i_s_axis_tdata,
    input  logic                      i_s_axis_tvalid,
    output logic                      o_s_axis_tready,
    input  logic                      i_s_axis_tlast,
    input  logic                      i_abort,
    output logic                      o_gate_pulse,
    output logic [8*SLEW_BYTES-1:0]   o_slew_remaining,
    output logic                      o_busy,
    output logic                      o_frame_err
);

    localparam int SW = 8 * SLEW_BYTES;
    localparam int EW = SW + 2;
    localparam int CW = $clog2(DIV_GATE + DIV_GATE_INCDEC_DELTA);
    localparam int IW = (SLEW_BYTES > 1) ? $clog2(SLEW_BYTES) : 1;

    localparam logic [CW-1:0] LD_NOM  = CW'(DIV_GATE - 1);
    localparam logic [CW-1:0] LD_FAST = CW'(DIV_GATE - 1 - DIV_GATE_INCDEC_DELTA);
    localparam logic [CW-1:0] LD_SLOW = CW'(DIV_GATE - 1 + DIV_GATE_INCDEC_DELTA);
    localparam logic [IW-1:0] IDX_LAST = IW'(SLEW_BYTES - 1);

    localparam logic signed [EW-1:0] SAT_MAX = {{3{1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{3{1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic {
        RX    = 1'b0,
        DRAIN = 1'b1
    } rx_state_t;

    rx_state_t state;
    rx_state_t state_nxt;

    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_nxt;
    logic signed [SW-1:0] rem;
    logic signed [SW-1:0] rem_nxt;
    logic                 step_up;
    logic                 step_dn;
    logic                 step_up_nxt;
    logic                 step_dn_nxt;
    logic                 pend;
    logic                 pend_nxt;
    logic [SW-1:0]        cmd;
    logic [SW-1:0]        frame_buf;
    logic [SW-1:0]        assembled;
    logic [IW-1:0]        idx;
    logic                 up;
    logic                 busy;

    logic                 boundary;
    logic                 accept;
    logic                 byte_last;
    logic                 frame_done;
    logic                 frame_err;
    logic                 store_byte;

    logic signed [EW-1:0] rem_ext;
    logic signed [EW-1:0] cmd_ext;
    logic signed [EW-1:0] step_val;
    logic signed [EW-1:0] sum;
    logic signed [SW-1:0] rem_sat;
    logic signed [SW-1:0] rem_bnd;

    assign boundary  = (cnt == '0);
    assign byte_last = (idx == IDX_LAST);

    // Ready is held low through reset and for one cycle after release.
    assign o_s_axis_tready = up & ((state == DRAIN) | ~pend);
    assign accept          = i_s_axis_tvalid & o_s_axis_tready;

    assign o_gate_pulse     = boundary;
    assign o_slew_remaining = rem;
    assign o_busy           = busy;
    assign o_frame_err      = frame_err;

    // Deserializer state register
    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            state <= RX;
        end else begin
            state <= state_nxt;
        end
    end

    // Deserializer next state
    always_comb begin
        state_nxt = state;
        if (i_abort) begin
            state_nxt = RX;
        end else if (accept) begin
            unique case (state)
                RX: begin
                    if (byte_last && !i_s_axis_tlast) begin
                        state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (i_s_axis_tlast) begin
                        state_nxt = RX;
                    end
                end
                default: state_nxt = RX;
            endcase
        end
    end

    // Deserializer outputs
    always_comb begin
        frame_err  = 1'b0;
        frame_done = 1'b0;
        store_byte = 1'b0;
        if (accept && !i_abort) begin
            unique case (state)
                RX: begin
                    store_byte = 1'b1;
                    frame_err  = i_s_axis_tlast & ~byte_last;
                    frame_done = i_s_axis_tlast & byte_last;
                end
                DRAIN: begin
                    frame_err = i_s_axis_tlast;
                end
                default: begin
                    frame_err = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            idx       <= '0;
            frame_buf <= '0;
        end else if (i_abort) begin
            idx <= '0;
        end else if (store_byte) begin
            for (int i = 0; i < SLEW_BYTES; i++) begin
                if (idx == IW'(i)) begin
                    frame_buf[8*i +: 8] <= i_s_axis_tdata;
                end
            end
            if (i_s_axis_tlast || byte_last) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Final byte lands directly in the top slot of the command word.
    always_comb begin
        assembled = frame_buf;
        assembled[SW-1 -: 8] = i_s_axis_tdata;
    end

    always_comb begin
        rem_ext  = $signed({{2{rem[SW-1]}}, rem});
        cmd_ext  = pend ? $signed({{2{cmd[SW-1]}}, cmd}) : '0;
        step_val = step_up ? EW'(1) : (step_dn ? '1 : '0);
        sum      = rem_ext - step_val + cmd_ext;
        if (sum > SAT_MAX) begin
            rem_sat = {1'b0, {(SW-1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            rem_sat = {1'b1, {(SW-1){1'b0}}};
        end else begin
            rem_sat = sum[SW-1:0];
        end
        rem_bnd = i_abort ? '0 : rem_sat;
    end

    // Period counter and slew bookkeeping next values
    always_comb begin
        cnt_nxt     = cnt - CW'(1);
        rem_nxt     = rem;
        step_up_nxt = step_up;
        step_dn_nxt = step_dn;
        if (boundary) begin
            rem_nxt     = rem_bnd;
            step_up_nxt = ~rem_bnd[SW-1] & (|rem_bnd);
            step_dn_nxt = rem_bnd[SW-1];
            unique case (1'b1)
                step_up_nxt: cnt_nxt = LD_FAST;
                step_dn_nxt: cnt_nxt = LD_SLOW;
                default:     cnt_nxt = LD_NOM;
            endcase
        end else if (i_abort) begin
            rem_nxt     = '0;
            step_up_nxt = 1'b0;
            step_dn_nxt = 1'b0;
        end
    end

    // A frame finishing on the boundary cycle survives the boundary clear.
    always_comb begin
        pend_nxt = pend;
        if (frame_done) begin
            pend_nxt = 1'b1;
        end else if (boundary || i_abort) begin
            pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk_gate or posedge rst_gate) begin
        if (rst_gate) begin
            cnt     <= LD_NOM;
            rem     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
            pend    <= 1'b0;
            cmd     <= '0;
            up      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            rem     <= rem_nxt;
            step_up <= step_up_nxt;
            step_dn <= step_dn_nxt;
            pend    <= pend_nxt;
            up      <= 1'b1;
            busy    <= (|rem_nxt) | pend_nxt;
            if (frame_done) begin
                cmd <= assembled;
            end
        end
    end

endmodule

// File: tb/tb_gate_slew_ctrl.sv
// Bench for gate_slew_ctrl: cycle model of period/slew rules plus pinned
// literal pulse times and remaining values for directed frames.
module tb_gate_slew_ctrl;

    localparam int DG = 20;
    localparam int DL = 2;
    localparam int SB = 4;
    localparam longint MAXV = 2147483647;
    localparam longint MINV = -MAXV - 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tdata = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        abort = 1'b0;
    logic        tready;
    logic        pulse;
    logic [31:0] rem;
    logic        busy;
    logic        ferr;

    always #5 clk = ~clk;

    gate_slew_ctrl #(
        .DIV_GATE(DG),
        .DIV_GATE_INCDEC_DELTA(DL),
        .SLEW_BYTES(SB)
    ) dut (
        .i_clk_gate(clk),
        .rst_gate(rst),
        .i_s_axis_tdata(tdata),
        .i_s_axis_tvalid(tvalid),
        .o_s_axis_tready(tready),
        .i_s_axis_tlast(tlast),
        .i_abort(abort),
        .o_gate_pulse(pulse),
        .o_slew_remaining(rem),
        .o_busy(busy),
        .o_frame_err(ferr)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tmo = 0;
    int scen = 0;
    bit fin_done = 1'b0;

    longint     m_rem;
    int         m_step;
    bit         m_pend;
    longint     m_cmd;
    logic [7:0] m_q[$];
    bit         m_drain;
    bit         m_up;
    int         m_next;

    int     plog[$];
    int     elog[$];
    longint rlog[$];
    bit     prev_p;

    function automatic longint pget(int i);
        return (i < plog.size()) ? longint'(plog[i]) : -1;
    endfunction

    function automatic longint rget(int i);
        return (i < rlog.size()) ? rlog[i] : -999;
    endfunction

    function automatic longint eget(int i);
        return (i < elog.size()) ? longint'(elog[i]) : -1;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s scen=%0d cyc=%0d got=%0d want=%0d",
                     nm, scen, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        bit     e_pulse;
        bit     e_ready;
        bit     acc;
        bit     e_ferr;
        longint r;
        longint ncmd;
        if (rst) begin
            cmp("rst_pulse", longint'(pulse), 0);
            cmp("rst_tready", longint'(tready), 0);
            cmp("rst_ferr", longint'(ferr), 0);
            cmp("rst_busy", longint'(busy), 0);
            cmp("rst_rem", longint'($signed(rem)), 0);
            m_rem = 0; m_step = 0; m_pend = 0; m_cmd = 0;
            m_q.delete(); m_drain = 0; m_up = 0; m_next = DG - 1;
            plog.delete(); elog.delete(); rlog.delete();
            prev_p = 0; cyc = 0;
        end else begin
            e_pulse = (cyc == m_next);
            e_ready = m_up && (m_drain || !m_pend);
            acc     = tvalid && e_ready;
            e_ferr  = acc && tlast && !abort && (m_drain || m_q.size() < SB - 1);
            cmp("pulse", longint'(pulse), longint'(e_pulse));
            cmp("tready", longint'(tready), longint'(e_ready));
            cmp("frame_err", longint'(ferr), longint'(e_ferr));
            cmp("remaining", longint'($signed(rem)), m_rem);
            cmp("busy", longint'(busy), longint'(m_rem != 0 || m_pend));
            if (pulse) plog.push_back(cyc);
            if (prev_p) rlog.push_back(longint'($signed(rem)));
            if (ferr) elog.push_back(cyc);
            prev_p = pulse;

            if (scen == 1 && cyc == 70) begin
                cmp("s1_npulse", plog.size(), 3);
                cmp("s1_p0", pget(0), 19);
                cmp("s1_p1", pget(1), 39);
                cmp("s1_p2", pget(2), 59);
            end
            if (scen == 2 && cyc == 73) cmp("s2_busy73", longint'(busy), 1);
            if (scen == 2 && cyc == 74) cmp("s2_busy74", longint'(busy), 0);
            if (scen == 2 && cyc == 100) begin
                cmp("s2_p1", pget(1), 37);
                cmp("s2_p2", pget(2), 55);
                cmp("s2_p3", pget(3), 73);
                cmp("s2_p4", pget(4), 93);
                cmp("s2_r0", rget(0), 3);
                cmp("s2_r1", rget(1), 2);
                cmp("s2_r2", rget(2), 1);
                cmp("s2_r3", rget(3), 0);
            end
            if (scen == 3 && cyc == 90) begin
                cmp("s3_p1", pget(1), 41);
                cmp("s3_p2", pget(2), 63);
                cmp("s3_p3", pget(3), 83);
                cmp("s3_r0", rget(0), -2);
                cmp("s3_r1", rget(1), -1);
                cmp("s3_r2", rget(2), 0);
            end
            if (scen == 4 && cyc == 60) begin
                cmp("s4_nerr", elog.size(), 2);
                cmp("s4_e0", eget(0), 2);
                cmp("s4_e1", eget(1), 8);
                cmp("s4_p1", pget(1), 37);
                cmp("s4_p2", pget(2), 57);
            end
            if (scen == 5 && cyc == 10) cmp("s5_stall", longint'(tready), 0);
            if (scen == 5 && cyc == 135) begin
                cmp("s5_r1", rget(1), 4);
                cmp("s5_p5", pget(5), 109);
                cmp("s5_p6", pget(6), 129);
            end
            if (scen == 6 && cyc == 40) cmp("s6_sat", longint'($signed(rem)), MAXV);
            if (scen == 6 && cyc == 57) begin
                cmp("s6_r1", rget(1), MAXV);
                cmp("s6_p2", pget(2), 55);
            end
            if (scen == 7 && cyc == 26) cmp("s7_pre", longint'($signed(rem)), 4);
            if (scen == 7 && cyc == 27) begin
                cmp("s7_abort_rem", longint'($signed(rem)), 0);
                cmp("s7_abort_busy", longint'(busy), 0);
            end
            if (scen == 7 && cyc == 80) begin
                cmp("s7_p1", pget(1), 37);
                cmp("s7_p2", pget(2), 55);
                cmp("s7_p3", pget(3), 75);
                cmp("s7_r1", rget(1), 1);
                cmp("s7_nerr", elog.size(), 0);
            end
            if (scen == 8 && cyc == 25) begin
                cmp("s8_npulse", plog.size(), 1);
                cmp("s8_p0", pget(0), 19);
            end
            if (scen == 99 && !fin_done) begin
                cmp("timeouts", tmo, 0);
                fin_done = 1'b1;
            end

            if (e_pulse) begin
                if (abort) begin
                    m_rem = 0;
                end else begin
                    r = m_rem - m_step + (m_pend ? m_cmd : 0);
                    if (r > MAXV) r = MAXV;
                    if (r < MINV) r = MINV;
                    m_rem = r;
                end
                m_step = (m_rem > 0) ? 1 : ((m_rem < 0) ? -1 : 0);
                m_next = cyc + DG - DL * m_step;
                m_pend = 0;
            end else if (abort) begin
                m_rem = 0;
                m_step = 0;
                m_pend = 0;
            end
            if (abort) begin
                m_q.delete();
                m_drain = 0;
            end else if (acc) begin
                if (m_drain) begin
                    if (tlast) m_drain = 0;
                end else if (m_q.size() == SB - 1) begin
                    if (tlast) begin
                        ncmd = longint'($signed({tdata, m_q[2], m_q[1], m_q[0]}));
                        m_cmd = ncmd;
                        m_pend = 1;
                    end else begin
                        m_drain = 1;
                    end
                    m_q.delete();
                end else if (tlast) begin
                    m_q.delete();
                end else begin
                    m_q.push_back(tdata);
                end
            end
            m_up = 1;
            cyc++;
        end
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        scen = n;
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        tdata = d;
        tlast = l;
        tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!tready) tmo++;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] v);
        for (int i = 0; i < SB; i++) begin
            send_byte(v[8*i +: 8], i == SB - 1);
        end
    endtask

    initial begin
        do_reset(1);
        wait_cyc(72);

        do_reset(2);
        wait_cyc(5);
        send_frame(32'h0000_0003);
        wait_cyc(102);

        do_reset(3);
        wait_cyc(5);
        send_frame(32'hFFFF_FFFE);
        wait_cyc(92);

        do_reset(4);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h30 + 8'(i), i == 5);
        end
        send_frame(32'h0000_0001);
        wait_cyc(62);

        do_reset(5);
        send_frame(32'h0000_0003);
        send_frame(32'h0000_0002);
        wait_cyc(137);

        do_reset(6);
        send_frame(32'h7FFF_FFFF);
        send_frame(32'h0000_0005);
        wait_cyc(59);

        do_reset(7);
        send_frame(32'h0000_0004);
        wait_cyc(24);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        send_frame(32'h0000_0001);
        wait_cyc(85);

        do_reset(8);
        wait_cyc(27);

        scen = 99;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_slew_ctrl.md
Name: gate_slew_ctrl

Overview:
- Actuation-side counterpart of the TDC measurement path: receives 8-bit AXI-S slew commands and produces the divided gate pulse in the i_clk_gate domain.
- Each command is a signed count of gate periods to shorten or lengthen by DIV_GATE_INCDEC_DELTA, giving fine phase steering of the gate.
- Command bytes are already in the i_clk_gate domain (async FIFO upstream); o_gate_pulse feeds the TDC S0 synchronizer.

Parameters:
- DIV_GATE, 2000000, nominal gate period in i_clk_gate cycles.
- DIV_GATE_INCDEC_DELTA, DIV_GATE/2000, cycles removed from or added to one slewed period.
- SLEW_BYTES, 4, bytes per command frame; slew word width SW = 8*SLEW_BYTES, signed two's complement.

Ports:
- i_clk_gate  in  1  gate clock.
- rst_gate  in  1  asynchronous, active-high reset.
- i_s_axis_tdata  in  8  command byte, little-endian.
- i_s_axis_tvalid  in  1  byte valid.
- o_s_axis_tready  out  1  byte accepted when tvalid & tready.
- i_s_axis_tlast  in  1  last byte of frame.
- i_abort  in  1  synchronous: clear all pending and outstanding slew.
- o_gate_pulse  out  1  one-cycle pulse at the end of each gate period.
- o_slew_remaining  out  SW  signed outstanding slew periods.
- o_busy  out  1  o_slew_remaining != 0 or a command is pending.
- o_frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset: all outputs 0; period counter = DIV_GATE-1; deserializer in RX with byte index 0; no pending command. o_s_axis_tready rises the first cycle after reset release.
- Period counter, width clog2(DIV_GATE+DIV_GATE_INCDEC_DELTA):
  - Counts down to 0; the period is load value + 1 cycles.
  - On count == 0: o_gate_pulse = 1 for that cycle, and the counter reloads.
  - First pulse occurs DIV_GATE cycles after reset release (at cycle index DIV_GATE-1).
- Load value, selected from the new remaining value (rem') at the boundary:
  - rem' > 0: DIV_GATE-1-DELTA, step = +1.
  - rem' < 0: DIV_GATE-1+DELTA, step = -1.
  - rem' == 0: DIV_GATE-1, step = 0.
  - The step is latched with the load and belongs to the period just started.
- At each boundary: rem' = sat_SW(rem - step_of_finished_period + (pending ? cmd : 0)).
  - Saturate to the signed SW range.
  - Clear pending.
  - The new command therefore affects the period starting on this same boundary.
- Deserializer states:
  - RX:
    - tready = !pending. Each accepted byte goes to slot idx; idx increments.
    - tlast with idx < SLEW_BYTES-1: discard, pulse o_frame_err, idx = 0.
    - Byte at idx == SLEW_BYTES-1 with tlast: assemble cmd, set pending, idx = 0.
    - Byte at idx == SLEW_BYTES-1 without tlast: discard, go to DRAIN.
  - DRAIN: tready = 1; discard bytes until an accepted byte has tlast, then pulse o_frame_err and go to RX.
- Pending is a single-entry holding register. While pending, tready = 0 in RX, so the next frame stalls until the next boundary.
  - A pending command of 0 is legal and is consumed normally.
- i_abort:
  - Next cycle: rem = 0, pending = 0, deserializer to RX with idx = 0. No o_frame_err pulse.
  - The current period finishes with its latched length; the step for that period is discarded.
- Simultaneous events:
  - Frame completion on the boundary cycle: the command is held for the following boundary, since the boundary samples the registered pending.
  - i_abort on the boundary cycle: abort wins, rem' = 0, and a nominal load is applied.
- o_busy and o_slew_remaining are registered and update the cycle after the boundary.

Test Plan:
All scenarios use DIV_GATE=20, DELTA=2, SLEW_BYTES=4.
- Idle after reset -> pulses at cycles 19, 39, 59…; o_busy = 0; remaining = 0.
- Frame 03 00 00 00 (tlast on 4th byte), completed mid-period -> next boundary starts three 18-cycle periods, then 20-cycle periods. Remaining reads 3, 2, 1, 0 at successive boundaries; o_busy falls after the third slewed period ends.
- Frame FE FF FF FF (-2) -> two 22-cycle periods, then nominal; remaining -2, -1, 0.
- tlast on 2nd byte -> o_frame_err pulse, no slew. 6 bytes with tlast on the 6th -> single o_frame_err at the 6th byte, no slew. A following valid +1 frame then works normally.
- Back-to-back +3 and +2 frames -> tready low after the first until the boundary; second applied at the next boundary for a 5 total; periods are 18 cycles throughout.
- Saturation and abort:
  - +0x7FFFFFFF then +5 -> remaining stays 0x7FFFFFFF.
  - i_abort mid-frame with remaining = 4 -> remaining 0 next cycle; the current 18-cycle period completes, then 20-cycle periods.
  - rst_gate asserted mid-period -> all outputs 0 immediately; first pulse 20 cycles after release.
